// File: rtl/led_pattern_ctrl.sv
// LED sequencer: synchronises and debounces the DIP pins, then drives the LED bank
// in PASS, CHASE, BLINK or COUNT mode, paced by a programmable tick prescaler.
module led_pattern_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 250000,
    parameter int unsigned TICK_DIV     = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dip,
    input  logic [1:0] mode,
    output logic [7:0] led,
    output logic       tick
);

    localparam int unsigned DB_W = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned TK_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 2);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_PASS  = 2'b00,
        MODE_CHASE = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_COUNT = 2'b11
    } mode_e;

    logic [7:0]      dip_s1, ds, ds_prev, dip_q;
    logic [1:0]      mode_s1, ms;
    logic [DB_W-1:0] db_cnt;
    logic [TK_W-1:0] presc;
    mode_e           mode_r;
    mode_e           ms_mode;
    logic            wrap;

    assign ms_mode = mode_e'(ms);
    assign wrap    = (presc == TK_LAST);

    // Two-flop synchronisers for the asynchronous pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dip_s1  <= 8'h00;
            ds      <= 8'h00;
            mode_s1 <= 2'b00;
            ms      <= 2'b00;
        end else begin
            dip_s1  <= dip;
            ds      <= dip_s1;
            mode_s1 <= mode;
            ms      <= mode_s1;
        end
    end

    // Debounce: dip_q follows ds only after an unbroken run of identical samples.
    // The compare against DEBOUNCE_CYC-2 lands the update on the edge the run completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ds_prev <= 8'h00;
            db_cnt  <= '0;
            dip_q   <= 8'h00;
        end else begin
            ds_prev <= ds;
            if ((ds != ds_prev) || (ds == dip_q)) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                dip_q  <= ds;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Mode FSM, prescaler and LED pattern; a mode change overrides any coincident tick action
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= MODE_PASS;
            presc  <= '0;
            led    <= 8'h00;
            tick   <= 1'b0;
        end else begin
            tick <= wrap;
            if (ms_mode != mode_r) begin
                mode_r <= ms_mode;
                presc  <= '0;
                case (ms_mode)
                    MODE_CHASE: led <= 8'h01;
                    MODE_COUNT: led <= 8'h00;
                    default:    led <= dip_q;
                endcase
            end else begin
                presc <= wrap ? '0 : presc + TK_W'(1);
                case (mode_r)
                    MODE_PASS:  led <= dip_q;
                    MODE_CHASE: if (wrap) led <= {led[6:0], led[7]};
                    MODE_BLINK: if (wrap) led <= (led == 8'h00) ? dip_q : 8'h00;
                    MODE_COUNT: if (wrap) led <= led + 8'd1;
                    default:    led <= led;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed vector table, hand sequences and a random
// phase, all checked against a sample-history reference model every clock.
module tb_led_pattern_ctrl;

    localparam int DC = 4;
    localparam int TD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dip;
    logic [1:0] mode;
    logic [7:0] led;
    logic       tick;

    int n_cmp = 0;
    int n_err = 0;

    led_pattern_ctrl #(.DEBOUNCE_CYC(DC), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .dip(dip), .mode(mode), .led(led), .tick(tick)
    );

    always #5 clk = ~clk;

    // Reference model: histories of raw pin samples, one entry per clock edge
    logic [7:0] m_dr [0:7];
    logic [1:0] m_mr [0:7];
    logic [7:0] m_led, m_dipq;
    logic [1:0] m_mode;
    logic       m_tick, m_tick_dc;
    int         m_since;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_dr[i] = 8'h00;
            m_mr[i] = 2'b00;
        end
        m_led = 8'h00; m_dipq = 8'h00; m_mode = 2'b00;
        m_tick = 1'b0; m_tick_dc = 1'b0; m_since = 0;
    endtask

    task automatic model_edge();
        bit         stable;
        bit         wrap;
        logic [1:0] ms;
        logic [7:0] old_q;
        stable = 1'b1;
        for (int i = 2; i <= DC; i++)
            if (m_dr[i] != m_dr[1]) stable = 1'b0;
        ms        = m_mr[1];
        old_q     = m_dipq;
        m_tick_dc = 1'b0;
        if (ms != m_mode) begin
            m_tick_dc = (((m_since + 1) % TD) == 0);
            m_tick    = 1'b0;
            m_mode    = ms;
            m_since   = 0;
            m_led     = (ms == 2'd1) ? 8'h01 : (ms == 2'd3) ? 8'h00 : old_q;
        end else begin
            m_since = m_since + 1;
            wrap    = ((m_since % TD) == 0);
            m_tick  = wrap;
            case (m_mode)
                2'd0: m_led = old_q;
                2'd1: if (wrap) m_led = {m_led[6:0], m_led[7]};
                2'd2: if (wrap) m_led = (m_led == 8'h00) ? old_q : 8'h00;
                default: if (wrap) m_led = m_led + 8'd1;
            endcase
        end
        if (stable && (m_dr[1] != m_dipq)) m_dipq = m_dr[1];
        for (int i = 7; i > 0; i--) begin
            m_dr[i] = m_dr[i-1];
            m_mr[i] = m_mr[i-1];
        end
        m_dr[0] = dip;
        m_mr[0] = mode;
    endtask

    task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge, compare just after it
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk8("model_led", led, m_led);
        if (!m_tick_dc) chk1("model_tick", tick, m_tick);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    typedef struct {
        logic [7:0] dip;
        logic [1:0] mode;
        int         cyc;
        logic [7:0] led;
        logic       tick;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{8'hA5, 2'd0, 6, 8'h00, 1'b0};
        vecs[1] = '{8'hA5, 2'd0, 1, 8'hA5, 1'b0};
        vecs[2] = '{8'h3C, 2'd0, 6, 8'hA5, 1'b0};
        vecs[3] = '{8'h3C, 2'd0, 1, 8'h3C, 1'b0};
        vecs[4] = '{8'h3C, 2'd1, 2, 8'h3C, 1'b1};
        vecs[5] = '{8'h3C, 2'd1, 1, 8'h01, 1'b0};
        vecs[6] = '{8'h3C, 2'd1, 7, 8'h01, 1'b0};
        vecs[7] = '{8'h3C, 2'd1, 1, 8'h02, 1'b1};
        vecs[8] = '{8'h3C, 2'd1, 1, 8'h02, 1'b0};
        vecs[9] = '{8'h3C, 2'd1, 7, 8'h04, 1'b1};

        rst_n = 1'b0;
        dip   = 8'hA5;
        mode  = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk8("reset_led", led, 8'h00);
        chk1("reset_tick", tick, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            dip  = vecs[i].dip;
            mode = vecs[i].mode;
            steps(vecs[i].cyc);
            chk8($sformatf("vec%0d_led", i), led, vecs[i].led);
            chk1($sformatf("vec%0d_tick", i), tick, vecs[i].tick);
        end

        // CHASE wraps 80 -> 01
        steps(40);
        chk8("chase_80", led, 8'h80);
        steps(8);
        chk8("chase_wrap", led, 8'h01);

        // Bounce on dip[0] never reaches dip_q; a held value does after 7 edges
        mode = 2'd0;
        steps(3);
        for (int i = 0; i < 10; i++) begin
            dip = dip ^ 8'h01;
            steps(2);
        end
        chk8("bounce_hold", led, 8'h3C);
        dip = 8'hC3;
        steps(6);
        chk8("debounce_6", led, 8'h3C);
        steps(1);
        chk8("debounce_7", led, 8'hC3);

        // BLINK with a dip change during the off phase
        dip = 8'hF0;
        steps(7);
        mode = 2'd2;
        steps(3);
        chk8("blink_entry", led, 8'hF0);
        steps(8);
        chk8("blink_off", led, 8'h00);
        steps(8);
        chk8("blink_on", led, 8'hF0);
        steps(8);
        dip = 8'h0F;
        steps(8);
        chk8("blink_new_dip", led, 8'h0F);
        steps(8);
        chk8("blink_off2", led, 8'h00);

        // COUNT wrap, then mode change landing on a tick
        mode = 2'd3;
        steps(3);
        chk8("count_entry", led, 8'h00);
        steps(255 * TD);
        chk8("count_ff", led, 8'hFF);
        steps(TD);
        chk8("count_wrap", led, 8'h00);
        steps(3 * TD);
        chk8("count_03", led, 8'h03);
        steps(TD - 3);
        mode = 2'd1;
        steps(3);
        chk8("modechg_on_tick", led, 8'h01);
        steps(TD);
        chk8("chase_after_chg", led, 8'h02);

        // Async reset mid-COUNT
        mode = 2'd3;
        steps(3);
        steps(8'h37 * TD);
        chk8("count_37", led, 8'h37);
        #1;
        mode  = 2'd0;
        rst_n = 1'b0;
        #1;
        chk8("async_rst_led", led, 8'h00);
        chk1("async_rst_tick", tick, 1'b0);
        rst_n = 1'b1;
        model_reset();
        steps(6);
        chk8("post_rst_6", led, 8'h00);
        steps(1);
        chk8("post_rst_7", led, 8'h0F);

        // Random pins, held for random lengths
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 2) != 0) dip = 8'($urandom);
            if ($urandom_range(0, 5) == 0) mode = 2'($urandom);
            steps($urandom_range(1, 14));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
